// File: rtl/enduro_gray_ptr_sync.sv
// Gray pointer synchronizer for enduro FIFO pointer crossings.
// A Gray pointer from the remote domain passes through a STAGES-deep flop chain.
// The synchronized value is converted to binary, and each change is reported as
// an advance (step). Any transition that changes more than one Gray bit raises a
// sticky error and increments a saturating counter.
module enduro_gray_ptr_sync #(
    parameter int BW     = 4,
    parameter int STAGES = 2,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [BW-1:0]    gray_in,
    input  logic             err_clr,
    output logic [BW-1:0]    gray_sync,
    output logic [BW-1:0]    bin_out,
    output logic             bin_valid,
    output logic [BW-1:0]    step,
    output logic             step_pulse,
    output logic             err_multi_bit,
    output logic [CNT_W-1:0] err_count
);

    // Reject unsupported parameter values at elaboration.
    if (STAGES < 2 || STAGES > 4) begin : g_bad_stages
        $error("enduro_gray_ptr_sync: STAGES must be in 2..4");
    end
    if (BW < 2) begin : g_bad_bw
        $error("enduro_gray_ptr_sync: BW must be >= 2");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("enduro_gray_ptr_sync: CNT_W must be >= 1");
    end

    // Warm-up counter: wide enough to hold STAGES+1.
    localparam int WC_W = $clog2(STAGES + 2);
    localparam logic [WC_W-1:0] WARM = WC_W'(STAGES + 1);

    // Gray to binary: b[BW-1] = g[BW-1], b[i] = b[i+1] ^ g[i].
    function automatic logic [BW-1:0] gray2bin(input logic [BW-1:0] g);
        logic [BW-1:0] b;
        b[BW-1] = g[BW-1];
        for (int i = BW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // True when more than one bit is set.
    function automatic logic multi_bit(input logic [BW-1:0] d);
        int ones;
        ones = 0;
        for (int i = 0; i < BW; i++) begin
            ones += int'(d[i]);
        end
        return (ones > 1);
    endfunction

    logic [BW-1:0]   sync_p [STAGES];
    logic [BW-1:0]   gray_q;
    logic [WC_W-1:0] wcnt;
    logic [BW-1:0]   bin_new;
    logic [BW-1:0]   bin_diff;
    logic            en;
    logic            err_ev;

    assign gray_sync = sync_p[STAGES-1];
    assign bin_new   = gray2bin(gray_sync);
    assign bin_diff  = bin_new - bin_out;
    // Comparisons are enabled only after bin_valid was already high. This keeps
    // the zeros left by reset from producing a spurious step or error.
    assign en        = bin_valid;
    assign err_ev    = en & multi_bit(gray_sync ^ gray_q);

    // Plain synchronizer chain; no logic between stages.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < STAGES; k++) begin
                sync_p[k] <= '0;
            end
        end else begin
            sync_p[0] <= gray_in;
            for (int k = 1; k < STAGES; k++) begin
                sync_p[k] <= sync_p[k-1];
            end
        end
    end

    // Binary stage, previous Gray sample, and warm-up tracking.
    always_ff @(posedge clk) begin
        if (reset) begin
            bin_out   <= '0;
            gray_q    <= '0;
            wcnt      <= '0;
            bin_valid <= 1'b0;
        end else begin
            bin_out <= bin_new;
            gray_q  <= gray_sync;
            if (wcnt != WARM) begin
                wcnt <= wcnt + 1'b1;
            end
            bin_valid <= (wcnt >= WARM - 1'b1);
        end
    end

    // Advance reporting. step keeps its last value between pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            step       <= '0;
            step_pulse <= 1'b0;
        end else begin
            step_pulse <= en & (bin_new != bin_out);
            if (en && (bin_new != bin_out)) begin
                step <= bin_diff;
            end
        end
    end

    // Multi-bit error tracking. If an event and err_clr arrive together, the event wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_multi_bit <= 1'b0;
            err_count     <= '0;
        end else if (err_ev) begin
            err_multi_bit <= 1'b1;
            if (err_clr) begin
                err_count <= CNT_W'(1);
            end else if (err_count != '1) begin
                err_count <= err_count + 1'b1;
            end
        end else if (err_clr) begin
            err_multi_bit <= 1'b0;
            err_count     <= '0;
        end
    end

endmodule

// File: tb/tb_enduro_gray_ptr_sync.sv
// Bench for enduro_gray_ptr_sync (BW=4, STAGES=2, CNT_W=2).
// Hand-written expectation tables cover reset, warm-up and a single multi-bit jump.
// A history-based reference model scores the longer sequences.
module tb_enduro_gray_ptr_sync;

    localparam int BW     = 4;
    localparam int STAGES = 2;
    localparam int CNT_W  = 2;
    localparam logic [CNT_W-1:0] CMAX = '1;

    logic             clk = 1'b0;
    logic             reset;
    logic [BW-1:0]    gray_in;
    logic             err_clr;
    logic [BW-1:0]    gray_sync;
    logic [BW-1:0]    bin_out;
    logic             bin_valid;
    logic [BW-1:0]    step;
    logic             step_pulse;
    logic             err_multi_bit;
    logic [CNT_W-1:0] err_count;

    enduro_gray_ptr_sync #(.BW(BW), .STAGES(STAGES), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .gray_in      (gray_in),
        .err_clr      (err_clr),
        .gray_sync    (gray_sync),
        .bin_out      (bin_out),
        .bin_valid    (bin_valid),
        .step         (step),
        .step_pulse   (step_pulse),
        .err_multi_bit(err_multi_bit),
        .err_count    (err_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [BW-1:0]    gsync;
        logic [BW-1:0]    bin;
        logic             valid;
        logic             pulse;
        logic [BW-1:0]    stp;
        logic             err;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    typedef struct {
        logic          rst;
        logic [BW-1:0] gin;
        logic          clr;
        exp_t          e;
    } vec_t;

    vec_t          tab[$];
    exp_t          sb[$];
    int            n_vec = 0;
    int            n_bad = 0;

    // Reference model state: Gray inputs captured at each edge since reset release.
    logic [BW-1:0]    ghist[$];
    logic [BW-1:0]    m_step;
    logic             m_pulse;
    logic             m_err;
    logic [CNT_W-1:0] m_cnt;

    function automatic logic [BW-1:0] ref_g2b(input logic [BW-1:0] g);
        return g ^ (g >> 1) ^ (g >> 2) ^ (g >> 3);
    endfunction

    function automatic logic [BW-1:0] to_gray(input int i);
        logic [BW-1:0] b;
        b = BW'(i);
        return b ^ (b >> 1);
    endfunction

    function automatic vec_t mk(input logic r, input logic [BW-1:0] g, input logic c,
                                input logic [BW-1:0] gs, input logic [BW-1:0] bn,
                                input logic v, input logic p, input logic [BW-1:0] st,
                                input logic er, input logic [CNT_W-1:0] cn);
        vec_t t;
        t.rst = r; t.gin = g; t.clr = c;
        t.e = '{gsync: gs, bin: bn, valid: v, pulse: p, stp: st, err: er, cnt: cn};
        return t;
    endfunction

    task automatic model(input logic r, input logic [BW-1:0] g, input logic c,
                         output exp_t m);
        int n;
        logic [BW-1:0] a, b;
        logic ev;
        if (r) begin
            ghist.delete();
            m_step = '0; m_pulse = 1'b0; m_err = 1'b0; m_cnt = '0;
            n = 0;
        end else begin
            ghist.push_back(g);
            n = ghist.size();
            ev = 1'b0;
            m_pulse = 1'b0;
            if (n >= STAGES + 2) begin
                a = ghist[n-STAGES-1];
                b = ghist[n-STAGES-2];
                ev = ($countones(a ^ b) > 1);
                m_pulse = (ref_g2b(a) != ref_g2b(b));
                if (m_pulse) m_step = ref_g2b(a) - ref_g2b(b);
            end
            if (ev) begin
                m_err = 1'b1;
                m_cnt = c ? CNT_W'(1) : ((m_cnt == CMAX) ? CMAX : m_cnt + 1'b1);
            end else if (c) begin
                m_err = 1'b0;
                m_cnt = '0;
            end
        end
        m.gsync = (n >= STAGES) ? ghist[n-STAGES] : '0;
        m.bin   = (n >= STAGES + 1) ? ref_g2b(ghist[n-STAGES-1]) : '0;
        m.valid = (n >= STAGES + 1);
        m.pulse = m_pulse;
        m.stp   = m_step;
        m.err   = m_err;
        m.cnt   = m_cnt;
    endtask

    // One clock: drive inputs on the falling edge, queue the expectation,
    // sample 1 time unit after the rising edge, then pop and compare.
    task automatic apply(input logic r, input logic [BW-1:0] g, input logic c,
                         input logic use_tab, input exp_t te, input string name);
        exp_t m, e, act;
        @(negedge clk);
        reset = r; gray_in = g; err_clr = c;
        model(r, g, c, m);
        sb.push_back(use_tab ? te : m);
        @(posedge clk);
        #1;
        act = '{gsync: gray_sync, bin: bin_out, valid: bin_valid, pulse: step_pulse,
                stp: step, err: err_multi_bit, cnt: err_count};
        e = sb.pop_front();
        n_vec++;
        if (act !== e) begin
            n_bad++;
            $display("FAIL %s: got gsync=%h bin=%h valid=%b pulse=%b step=%h err=%b cnt=%h, expected gsync=%h bin=%h valid=%b pulse=%b step=%h err=%b cnt=%h",
                     name, act.gsync, act.bin, act.valid, act.pulse, act.stp, act.err, act.cnt,
                     e.gsync, e.bin, e.valid, e.pulse, e.stp, e.err, e.cnt);
        end
    endtask

    task automatic run(input logic r, input logic [BW-1:0] g, input logic c, input string name);
        apply(r, g, c, 1'b0, '0, name);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; gray_in = '0; err_clr = 1'b0;

        // Reset, then hold 0: bin_valid rises 3 edges after release.
        tab.push_back(mk(1, 4'h0, 0, 4'h0, 4'h0, 0, 0, 4'h0, 0, 2'd0));
        tab.push_back(mk(0, 4'h0, 0, 4'h0, 4'h0, 0, 0, 4'h0, 0, 2'd0));
        tab.push_back(mk(0, 4'h0, 0, 4'h0, 4'h0, 0, 0, 4'h0, 0, 2'd0));
        tab.push_back(mk(0, 4'h0, 0, 4'h0, 4'h0, 1, 0, 4'h0, 0, 2'd0));
        tab.push_back(mk(0, 4'h0, 0, 4'h0, 4'h0, 1, 0, 4'h0, 0, 2'd0));
        tab.push_back(mk(0, 4'h0, 0, 4'h0, 4'h0, 1, 0, 4'h0, 0, 2'd0));
        // Reset with 0110 held: bin_out=4 at edge 3 and no pulse.
        tab.push_back(mk(1, 4'h6, 0, 4'h0, 4'h0, 0, 0, 4'h0, 0, 2'd0));
        tab.push_back(mk(0, 4'h6, 0, 4'h0, 4'h0, 0, 0, 4'h0, 0, 2'd0));
        tab.push_back(mk(0, 4'h6, 0, 4'h6, 4'h0, 0, 0, 4'h0, 0, 2'd0));
        tab.push_back(mk(0, 4'h6, 0, 4'h6, 4'h4, 1, 0, 4'h0, 0, 2'd0));
        tab.push_back(mk(0, 4'h6, 0, 4'h6, 4'h4, 1, 0, 4'h0, 0, 2'd0));
        tab.push_back(mk(0, 4'h6, 0, 4'h6, 4'h4, 1, 0, 4'h0, 0, 2'd0));
        // Jump 0000 -> 0011: err, count and step=2 on the same edge; flag stays set.
        tab.push_back(mk(1, 4'h0, 0, 4'h0, 4'h0, 0, 0, 4'h0, 0, 2'd0));
        tab.push_back(mk(0, 4'h0, 0, 4'h0, 4'h0, 0, 0, 4'h0, 0, 2'd0));
        tab.push_back(mk(0, 4'h0, 0, 4'h0, 4'h0, 0, 0, 4'h0, 0, 2'd0));
        tab.push_back(mk(0, 4'h0, 0, 4'h0, 4'h0, 1, 0, 4'h0, 0, 2'd0));
        tab.push_back(mk(0, 4'h0, 0, 4'h0, 4'h0, 1, 0, 4'h0, 0, 2'd0));
        tab.push_back(mk(0, 4'h3, 0, 4'h0, 4'h0, 1, 0, 4'h0, 0, 2'd0));
        tab.push_back(mk(0, 4'h3, 0, 4'h3, 4'h0, 1, 0, 4'h0, 0, 2'd0));
        tab.push_back(mk(0, 4'h3, 0, 4'h3, 4'h2, 1, 1, 4'h2, 1, 2'd1));
        tab.push_back(mk(0, 4'h3, 0, 4'h3, 4'h2, 1, 0, 4'h2, 1, 2'd1));
        tab.push_back(mk(0, 4'h3, 0, 4'h3, 4'h2, 1, 0, 4'h2, 1, 2'd1));

        for (int i = 0; i < tab.size(); i++) begin
            apply(tab[i].rst, tab[i].gin, tab[i].clr, 1'b1, tab[i].e, $sformatf("tab%0d", i));
        end

        // Gray count 0..15 with wrap, one value per cycle.
        run(1, 4'h0, 0, "cnt_rst");
        for (int i = 0; i < 4; i++) run(0, 4'h0, 0, "cnt_warm");
        for (int i = 1; i <= 20; i++) run(0, to_gray(i), 0, $sformatf("cnt%0d", i));
        for (int i = 0; i < 3; i++) run(0, to_gray(20), 0, "cnt_hold");

        // Saturating error count, then err_clr colliding with a 6th event, then clear alone.
        run(1, 4'h0, 0, "sat_rst");
        for (int i = 0; i < 4; i++) run(0, 4'h0, 0, "sat_warm");
        for (int i = 0; i < 5; i++) run(0, (i % 2 == 0) ? 4'h3 : 4'h0, 0, $sformatf("sat_ev%0d", i));
        run(0, 4'h3, 0, "sat_hold0");
        run(0, 4'h3, 0, "sat_hold1");
        run(0, 4'h0, 0, "sat_ev6");
        run(0, 4'h0, 0, "sat_ev6_pipe");
        run(0, 4'h0, 1, "sat_collide");
        run(0, 4'h0, 0, "sat_after");
        run(0, 4'h0, 1, "clr_alone");
        run(0, 4'h0, 0, "clr_after");

        // One-cycle reset in the middle of a count.
        run(1, 4'h0, 0, "mid_rst0");
        for (int i = 0; i < 4; i++) run(0, 4'h0, 0, "mid_warm");
        for (int i = 1; i <= 6; i++) run(0, to_gray(i), 0, $sformatf("mid_pre%0d", i));
        run(1, to_gray(7), 0, "mid_reset");
        for (int i = 8; i <= 16; i++) run(0, to_gray(i), 0, $sformatf("mid_post%0d", i));
        for (int i = 0; i < 3; i++) run(0, to_gray(16), 0, "mid_hold");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
